// File: rtl/rotate_sequencer.sv
// rotate_sequencer: multi-cycle rotate/shift engine.
// Captures an operand and an amount on start. It then walks the operand with 2-bit steps,
// plus one final 1-bit step when the amount is odd.
// The result, carry-out and a one-cycle done pulse are all registered.
module rotate_sequencer #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [AMT_W-1:0] amt,
    input  logic             dir,
    input  logic [1:0]       mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] MODE_ROT = 2'b00;
    localparam logic [1:0] MODE_LSH = 2'b01;
    localparam logic [1:0] MODE_ASH = 2'b10;

    state_t             r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [AMT_W-1:0]   r_rem;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic               r_sign;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_y;
    logic               r_c_out;

    logic               w_step_two;
    logic [AMT_W-1:0]   w_step_amt;
    logic [AMT_W-1:0]   w_rem_next;
    logic [WIDTH:0]     w_step;

    // One 1- or 2-bit step of the datapath rotate unit.
    // The return value is {carry, result}.
    // Mode 11 is treated as rotate, and an arithmetic left step is the same as a logical left step.
    function automatic logic [WIDTH:0] step_fn(
        input logic [WIDTH-1:0] acc,
        input logic             two,
        input logic             right,
        input logic [1:0]       md,
        input logic             sign
    );
        logic [1:0] fill;
        logic       carry;
        logic [WIDTH-1:0] res;
        fill  = 2'b00;
        carry = 1'b0;
        res   = acc;
        if (right) begin
            case (md)
                MODE_ROT: fill = two ? acc[1:0] : {acc[0], 1'b0};
                MODE_LSH: fill = 2'b00;
                MODE_ASH: fill = {sign, sign};
                default:  fill = two ? acc[1:0] : {acc[0], 1'b0};
            endcase
            if (two) begin
                carry = acc[1];
                res   = {fill, acc[WIDTH-1:2]};
            end else begin
                carry = acc[0];
                res   = {fill[1], acc[WIDTH-1:1]};
            end
        end else begin
            case (md)
                MODE_ROT: fill = two ? acc[WIDTH-1:WIDTH-2] : {1'b0, acc[WIDTH-1]};
                MODE_LSH: fill = 2'b00;
                MODE_ASH: fill = 2'b00;
                default:  fill = two ? acc[WIDTH-1:WIDTH-2] : {1'b0, acc[WIDTH-1]};
            endcase
            if (two) begin
                carry = acc[WIDTH-2];
                res   = {acc[WIDTH-3:0], fill};
            end else begin
                carry = acc[WIDTH-1];
                res   = {acc[WIDTH-2:0], fill[0]};
            end
        end
        return {carry, res};
    endfunction

    // Step size and next-step datapath for the current RUN cycle.
    always_comb begin
        w_step_two = (r_rem >= AMT_W'(2));
        if (w_step_two) begin
            w_step_amt = AMT_W'(2);
        end else begin
            w_step_amt = AMT_W'(1);
        end
        w_rem_next = r_rem - w_step_amt;
        w_step     = step_fn(r_acc, w_step_two, r_dir, r_mode, r_sign);
    end

    // Sequencer FSM with registered status and result outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= 2'b00;
            r_sign  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_y     <= '0;
            r_c_out <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_acc  <= a;
                        r_rem  <= amt;
                        r_dir  <= dir;
                        r_mode <= mode;
                        r_sign <= a[WIDTH-1];
                        if (amt == AMT_W'(0)) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_y     <= a;
                            r_c_out <= 1'b0;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_step[WIDTH-1:0];
                    r_rem <= w_rem_next;
                    if (w_rem_next == AMT_W'(0)) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_y     <= w_step[WIDTH-1:0];
                        r_c_out <= w_step[WIDTH];
                    end else begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign y     = r_y;
    assign c_out = r_c_out;

endmodule
